// File: rtl/mest_pro_input.sv
// mest_pro_input: 4x4 hex keypad front-end.
//
// Drives the keypad columns one at a time (active-low), samples the
// synchronised rows at the end of each column slot, and collects one key per
// four-column frame. A debounce FSM acts only at frame boundaries. A key must
// be seen in DEBOUNCE consecutive frames before it is reported. The key must
// then be absent for DEBOUNCE consecutive frames before another key can be
// reported. Reported keys are presented on a valid/ack handshake.
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst            asynchronous active-high reset
//   i_input_enable scanner enable; low idles the scanner and clears outputs
//   i_rows[3:0]    keypad rows, active-low, asynchronous to clk
//   o_cols[3:0]    keypad columns, active-low, one-hot-low while scanning
//   o_key_val      encoded key {0, row*4+col}, stable while o_key_valid=1
//   o_key_valid    o_key_val holds an unconsumed key
//   i_key_ack      consumer accepts the key (ignored while o_key_valid=0)
//   o_overflow     sticky: a key was dropped while valid was still pending
module mest_pro_input #(
  parameter int MEM_WIDTH = 16,
  parameter int SCAN_DIV  = 1000,
  parameter int DEBOUNCE  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_input_enable,
  input  logic [3:0]           i_rows,
  output logic [3:0]           o_cols,
  output logic [MEM_WIDTH-1:0] o_key_val,
  output logic                 o_key_valid,
  input  logic                 i_key_ack,
  output logic                 o_overflow
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, REPORT, HELD} state_t;

  // Row synchroniser. Idle value is all-high (no key), matching the pull-ups.
  logic [3:0] rows_meta;
  logic [3:0] rows_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_meta <= 4'hF;
      rows_sync <= 4'hF;
    end else begin
      rows_meta <= i_rows;
      rows_sync <= rows_meta;
    end
  end

  // Column scan. o_cols is registered from the next column value so the
  // driven column lines up with col, which leaves the synchroniser the whole
  // slot to settle before the sample on the slot's last cycle.
  logic [SLOT_W-1:0] slot;
  logic [1:0]        col;
  logic              slot_last;
  logic              frame_end;
  logic [1:0]        col_next;

  assign slot_last = (slot == SLOT_W'(SCAN_DIV - 1));
  assign frame_end = slot_last && (col == 2'd3);
  assign col_next  = slot_last ? col + 2'd1 : col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot   <= '0;
      col    <= 2'd0;
      o_cols <= 4'hF;
    end else if (!i_input_enable) begin
      slot   <= '0;
      col    <= 2'd0;
      o_cols <= 4'hF;
    end else begin
      slot   <= slot_last ? '0 : slot + SLOT_W'(1);
      col    <= col_next;
      o_cols <= ~(4'b0001 << col_next);
    end
  end

  // Lowest active row in the current column.
  logic       hit;
  logic [1:0] hit_row;
  logic [3:0] sample_code;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!rows_sync[r]) begin
        hit     = 1'b1;
        hit_row = 2'(r);
      end
    end
  end

  assign sample_code = {hit_row, col};

  // Frame accumulator: remembers the first key seen in scan order. The col3
  // sample is folded in combinationally at the frame-end cycle itself.
  logic       frame_found;
  logic [3:0] frame_code;
  logic       key_present;
  logic [3:0] key_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_found <= 1'b0;
      frame_code  <= 4'd0;
    end else if (!i_input_enable) begin
      frame_found <= 1'b0;
      frame_code  <= 4'd0;
    end else if (slot_last) begin
      if (frame_end) begin
        frame_found <= 1'b0;
        frame_code  <= 4'd0;
      end else if (hit && !frame_found) begin
        frame_found <= 1'b1;
        frame_code  <= sample_code;
      end
    end
  end

  assign key_present = frame_found || hit;
  assign key_code    = frame_found ? frame_code : sample_code;

  // Debounce FSM: state register.
  state_t           state, state_next;
  logic [3:0]       cand, cand_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] rel_cnt, rel_next;
  logic             issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cand    <= 4'd0;
      cnt     <= '0;
      rel_cnt <= '0;
    end else if (!i_input_enable) begin
      state   <= IDLE;
      cand    <= 4'd0;
      cnt     <= '0;
      rel_cnt <= '0;
    end else begin
      state   <= state_next;
      cand    <= cand_next;
      cnt     <= cnt_next;
      rel_cnt <= rel_next;
    end
  end

  // Debounce FSM: next state. Only frame ends move it, except REPORT,
  // which always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    rel_next   = rel_cnt;
    unique case (state)
      IDLE: begin
        if (frame_end && key_present) begin
          cand_next  = key_code;
          cnt_next   = CNT_W'(1);
          state_next = (DEBOUNCE == 1) ? REPORT : PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (frame_end) begin
          if (!key_present) begin
            state_next = IDLE;
          end else if (key_code == cand) begin
            cnt_next = cnt + CNT_W'(1);
            if (cnt_next == CNT_W'(DEBOUNCE)) state_next = REPORT;
          end else begin
            cand_next = key_code;
            cnt_next  = CNT_W'(1);
          end
        end
      end
      REPORT: begin
        state_next = HELD;
        rel_next   = '0;
      end
      HELD: begin
        if (frame_end) begin
          if (key_present) begin
            rel_next = '0;
          end else begin
            rel_next = rel_cnt + CNT_W'(1);
            if (rel_next == CNT_W'(DEBOUNCE)) state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Debounce FSM: outputs.
  always_comb begin
    issue = (state == REPORT);
  end

  // Output handshake stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_key_val   <= '0;
      o_key_valid <= 1'b0;
      o_overflow  <= 1'b0;
    end else if (!i_input_enable) begin
      o_key_val   <= '0;
      o_key_valid <= 1'b0;
      o_overflow  <= 1'b0;
    end else if (issue) begin
      if (!o_key_valid) begin
        o_key_val   <= MEM_WIDTH'(cand);
        o_key_valid <= 1'b1;
      end else if (i_key_ack) begin
        // Consumer frees the slot in the same cycle: the new key takes it.
        o_key_val   <= MEM_WIDTH'(cand);
        o_key_valid <= 1'b1;
        o_overflow  <= 1'b0;
      end else begin
        o_overflow  <= 1'b1;
      end
    end else if (i_key_ack && o_key_valid) begin
      o_key_valid <= 1'b0;
      o_overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mest_pro_input.sv
// Self-checking bench for mest_pro_input (SCAN_DIV=4, DEBOUNCE=3).
// A keypad model turns a 16-bit pressed-key mask into active-low rows from the
// driven columns. A frame-level reference model predicts every output on
// every cycle. Directed scenarios add hand-computed literal expectations, and a
// randomized phase follows them.
module tb_mest_pro_input;

  localparam int MEM_WIDTH = 16;
  localparam int SCAN_DIV  = 4;
  localparam int DEBOUNCE  = 3;
  localparam int FRAME     = 4 * SCAN_DIV;
  localparam int NONE      = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en  = 1'b1;
  logic                 ack = 1'b0;
  logic [15:0]          keys = 16'h0000;
  logic [3:0]           rows;
  logic [3:0]           cols;
  logic [MEM_WIDTH-1:0] key_val;
  logic                 key_valid;
  logic                 overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  mest_pro_input #(
    .MEM_WIDTH(MEM_WIDTH),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_input_enable(en),
    .i_rows        (rows),
    .o_cols        (cols),
    .o_key_val     (key_val),
    .o_key_valid   (key_valid),
    .i_key_ack     (ack),
    .o_overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc       = 0;
  logic [3:0]  exp_cols  = 4'hF;
  logic [15:0] exp_val   = 16'h0000;
  logic        exp_valid = 1'b0;
  logic        exp_ovf   = 1'b0;
  int          hist[$];
  bit          armed     = 1'b1;
  bit          pend      = 1'b0;
  int          pend_code = 0;

  // First key in scan order: column 0 first, lowest row within a column.
  function automatic int frame_key(input logic [15:0] m);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (m[r*4+c]) return r*4 + c;
    return NONE;
  endfunction

  // True when the last DEBOUNCE frames all produced value v.
  function automatic bit tail_all(input int v);
    if (hist.size() < DEBOUNCE) return 1'b0;
    for (int i = hist.size() - DEBOUNCE; i < hist.size(); i++)
      if (hist[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    cyc       = 0;
    exp_cols  = 4'hF;
    exp_val   = 16'h0000;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    hist.delete();
    armed     = 1'b1;
    pend      = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst || !en) begin
      model_clear();
    end else begin
      int fk;
      if (pend) begin
        if (!exp_valid || ack) begin
          exp_val   = 16'(pend_code);
          exp_valid = 1'b1;
          exp_ovf   = 1'b0;
        end else begin
          exp_ovf = 1'b1;
        end
      end else if (ack && exp_valid) begin
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
      end
      pend = 1'b0;
      if (cyc == FRAME - 1) begin
        fk = frame_key(keys);
        hist.push_back(fk);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        if (armed && fk != NONE && tail_all(fk)) begin
          pend      = 1'b1;
          pend_code = fk;
          armed     = 1'b0;
        end else if (!armed && tail_all(NONE)) begin
          armed = 1'b1;
        end
      end
      cyc = (cyc + 1) % FRAME;
      exp_cols = 4'hF;
      exp_cols[cyc/SCAN_DIV] = 1'b0;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("cols",     32'(cols),      32'(exp_cols));
    check("key_val",  32'(key_val),   32'(exp_val));
    check("valid",    32'(key_valid), 32'(exp_valid));
    check("overflow", 32'(overflow),  32'(exp_ovf));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input logic [15:0] m, input int n);
    keys = m;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ack1();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  localparam logic [15:0] K9 = 16'h0200;                // row2/col1
  localparam logic [15:0] K5 = 16'h0020;                // row1/col1
  localparam logic [15:0] KA = 16'h0400;                // row2/col2
  localparam logic [15:0] KM = 16'h1004;                // row3/col0 + row0/col2
  localparam logic [15:0] K7 = 16'h0080;                // row1/col3
  localparam logic [15:0] K3 = 16'h0008;                // row0/col3

  initial begin
    logic [15:0] m;
    repeat (3) step();
    check("rst_valid", 32'(key_valid), 32'h0);
    rst = 1'b0;
    check("cols_before_clk", 32'(cols), 32'hF);
    step();
    check("cols_first_clk", 32'(cols), 32'hE);
    run(16'h0, FRAME - 1);

    // Single key, acked while held, never re-reported.
    run(K9, 3 * FRAME);
    check("single_not_yet", 32'(key_valid), 32'h0);
    run(K9, 1);
    check("single_valid", 32'(key_valid), 32'h1);
    check("single_val", 32'(key_val), 32'h0009);
    run(K9, FRAME - 1);
    run(K9, FRAME);
    ack1();
    check("single_acked", 32'(key_valid), 32'h0);
    run(K9, FRAME - 1);
    run(K9, 3 * FRAME);
    check("single_no_repeat", 32'(key_valid), 32'h0);
    run(16'h0, 3 * FRAME);

    // Bounce: down 1, up 1, down 3.
    run(K5, FRAME);
    run(16'h0, FRAME);
    run(K5, 2 * FRAME);
    check("bounce_not_yet", 32'(key_valid), 32'h0);
    run(K5, FRAME);
    run(K5, 1);
    check("bounce_valid", 32'(key_valid), 32'h1);
    check("bounce_val", 32'(key_val), 32'h0005);
    run(K5, FRAME - 1);

    // Overflow: second key while 5 is still pending.
    run(16'h0, 3 * FRAME);
    run(KA, 3 * FRAME);
    run(KA, 1);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_val_kept", 32'(key_val), 32'h0005);
    run(KA, FRAME - 1);
    ack1();
    check("ovf_ack_valid", 32'(key_valid), 32'h0);
    check("ovf_ack_flag", 32'(overflow), 32'h0);
    run(KA, FRAME - 1);
    run(16'h0, 3 * FRAME);

    // Multi-key: column 0 wins.
    run(KM, 3 * FRAME);
    run(KM, 1);
    check("multi_val", 32'(key_val), 32'h000C);
    run(KM, FRAME - 1);
    ack1();
    run(KM, FRAME - 1);
    run(16'h0, 3 * FRAME);

    // Enable drop after two debounce frames.
    run(K7, 2 * FRAME);
    en = 1'b0;
    step();
    check("dis_cols", 32'(cols), 32'hF);
    check("dis_valid", 32'(key_valid), 32'h0);
    run(K7, 5);
    en = 1'b1;
    run(K7, 2 * FRAME);
    check("reen_not_yet", 32'(key_valid), 32'h0);
    run(K7, FRAME);
    run(K7, 1);
    check("reen_valid", 32'(key_valid), 32'h1);
    check("reen_val", 32'(key_val), 32'h0007);
    run(K7, FRAME - 1);
    ack1();
    run(K7, FRAME - 1);
    run(16'h0, 3 * FRAME);

    // Reset mid-scan with a key held and a key pending.
    run(K3, 3 * FRAME);
    run(K3, 1);
    run(K3, 7);
    rst = 1'b1;
    #1;
    check("rst_cols", 32'(cols), 32'hF);
    check("rst_val", 32'(key_val), 32'h0);
    check("rst_valid_mid", 32'(key_valid), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    step();
    step();
    rst = 1'b0;
    run(K3, 3 * FRAME);
    run(K3, 1);
    check("post_rst_val", 32'(key_val), 32'h0003);
    run(K3, FRAME - 1);
    ack1();
    run(K3, FRAME - 1);
    run(16'h0, 3 * FRAME);

    // Randomized frames with random acks.
    m = 16'h0;
    for (int f = 0; f < 120; f++) begin
      int sel;
      sel = $urandom_range(99);
      if (sel < 25)      m = 16'h0;
      else if (sel < 45) m = 16'h1 << $urandom_range(15);
      else if (sel < 50) m = (16'h1 << $urandom_range(15)) | (16'h1 << $urandom_range(15));
      keys = m;
      for (int i = 0; i < FRAME; i++) begin
        ack = ($urandom_range(9) == 0);
        step();
      end
    end
    ack = 1'b0;
    run(16'h0, 2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mest_pro_input.md
Name: mest_pro_input

Overview:
Hex keypad front-end for the MESTPro core; the input-side counterpart to the 7-segment display driver. It scans a 4x4 matrix keypad, synchronises and debounces the rows, and encodes one pressed key into a hex value 0x0-0xF. The value is presented as a MEM_WIDTH-wide word with a valid/ack handshake so the core can store it to memory.

Parameters:
MEM_WIDTH, 16, width of o_key_val; must be >= 4.
SCAN_DIV, 1000, clk cycles each column is driven; must be >= 4.
DEBOUNCE, 4, consecutive identical scan frames required for both press and release; must be >= 1.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  asynchronous, active-high reset.
i_input_enable  input  1  scanner enable; low = scanner idle and outputs cleared.
i_rows  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk.
o_cols  output  4  keypad columns, active-low, one-hot-low while scanning.
o_key_val  output  MEM_WIDTH  encoded key, zero-extended 4-bit code.
o_key_valid  output  1  o_key_val holds an unconsumed key.
i_key_ack  input  1  consumer accepts the key; counts only while o_key_valid=1.
o_overflow  output  1  sticky flag: a debounced key was dropped because valid was still pending.

Behaviour:
- Reset (async, rst=1): o_cols=4'hF, o_key_val=0, o_key_valid=0, o_overflow=0, col=0, slot counter=0, FSM=IDLE, synchroniser flops=4'hF.
- i_rows passes through a 2-flop synchroniser before use.
- Scan: col counter 0..3, each held SCAN_DIV cycles, wraps 3->0. o_cols = ~(4'b0001 << col).
- Sampling: on the last cycle of each column slot, the synchronised rows are sampled for that column. The lowest active row index wins. Key code = row*4 + col.
- Frame: 4 slots = 4*SCAN_DIV cycles. The frame key is the first key found in scan order (col0 first), or NONE. It is evaluated at the end of the col3 slot.
- FSM, updated only at frame end:
  - IDLE: frame key present -> cand=key, cnt=1. If DEBOUNCE=1 -> REPORT, else -> PRESS_DB.
  - PRESS_DB: frame key==cand -> cnt+1; reaching DEBOUNCE -> REPORT. A different key -> cand=new key, cnt=1, stay. NONE -> IDLE.
  - REPORT: one-cycle state; issue the key to the output stage -> HELD with rel_cnt=0.
  - HELD: NONE -> rel_cnt+1; reaching DEBOUNCE -> IDLE. Any key -> rel_cnt=0. A held key is never re-reported (no auto-repeat).
- Output stage:
  - Issue with o_key_valid=0: o_key_val={0, code}, o_key_valid=1 next cycle.
  - Issue with o_key_valid=1 and no ack that cycle: key dropped, o_key_val unchanged, o_overflow=1.
  - i_key_ack with o_key_valid=1: o_key_valid=0 and o_overflow=0 next cycle.
  - Issue and ack in the same cycle: new key loads, o_key_valid stays 1, o_overflow=0.
  - Ack while o_key_valid=0 is ignored.
- Latency: a key stable from a frame start reports DEBOUNCE*4*SCAN_DIV + 2 cycles later, +/-1 cycle for REPORT. o_key_val is stable while o_key_valid=1.
- i_input_enable=0 (synchronous, each cycle): o_cols=4'hF, col=0, slot counter=0, FSM=IDLE, o_key_valid=0, o_key_val=0, o_overflow=0. When re-enabled, scanning restarts at col0 with a fresh frame.
- Reset or disable mid-debounce discards the candidate. No partial frame is ever evaluated.

Test Plan:
- Reset: assert rst mid-scan with a key held -> o_cols=4'hF, o_key_val=0, o_key_valid=0, o_overflow=0 immediately. Deassert -> o_cols=4'hE after the first clock.
- Single key (SCAN_DIV=4, DEBOUNCE=3): hold row2/col1 for 10 frames -> o_key_valid rises once ~3 frames (48 cycles) after the first full frame, o_key_val=16'h0009. Pulse i_key_ack -> o_key_valid=0 next cycle, no re-report while held.
- Bounce: key 5 down 1 frame, up 1 frame, down 3 frames -> exactly one report, 16'h0005, only after the 3 consecutive frames.
- Overflow: report 5, release for 3 frames, press row2/col2 (0xA) for 3 frames, no ack -> o_key_val stays 0x5, o_overflow=1. Then ack -> o_key_valid=0, o_overflow=0.
- Multi-key: row3/col0 and row0/col2 pressed together -> o_key_val=16'h000C (col0 wins in scan order).
- Enable drop: deassert i_input_enable after 2 debounce frames -> o_cols=4'hF, o_key_valid=0. Re-enable with key still held -> report only after 3 fresh frames starting at col0.
